// File: rtl/perceptron_trainer_n.sv
// Perceptron trainer: N_IN-input bipolar perceptron, Fausett rule (alpha = 1),
// trained over an internal sample RAM. Epochs repeat until one epoch makes no
// update or MAX_EPOCH epochs have run. Weight and bias arithmetic saturates.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | results valid, sample RAM writable, waiting for start
// CLEAR     | zero weights/bias/status, k = 0, u = 0
// FETCH     | read sample k into the sample register, acc = bias
// MAC       | acc += w[i]*x[i], one lane per cycle
// DECIDE    | threshold acc against +/-THETA, compare with target
// UPDATE    | w[i] += t*x[i], bias += t (saturating), mark epoch dirty
// EPOCH_END | epochs++, then converge / hit epoch limit / next epoch
module perceptron_trainer_n #(
    parameter int N_IN      = 2,
    parameter int DW        = 14,
    parameter int DEPTH     = 16,
    parameter int MAX_EPOCH = 64,
    parameter int THETA     = 0,
    localparam int AW       = $clog2(DEPTH),
    localparam int EW       = $clog2(MAX_EPOCH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [N_IN*DW-1:0]   wr_x,
    input  logic                 wr_t,
    input  logic [AW:0]          n_samples,
    output logic                 ready,
    output logic                 converged,
    output logic [EW-1:0]        epochs,
    output logic [N_IN*DW-1:0]   weights,
    output logic [DW-1:0]        bias
);

    // Accumulator is wide enough for bias plus N_IN full-scale products.
    localparam int ACC_W = 2 * DW + $clog2(N_IN + 1);
    localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int SW    = N_IN * DW + 1;

    localparam logic signed [ACC_W-1:0] TH_POS  = ACC_W'(THETA);
    localparam logic signed [ACC_W-1:0] TH_NEG  = ACC_W'(-THETA);
    localparam logic signed [DW+1:0]    SAT_HI  = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [DW+1:0]    SAT_LO  = {3'b111, {(DW-1){1'b0}}};
    localparam logic signed [DW+1:0]    ONE_P   = (DW+2)'(1);
    localparam logic signed [DW+1:0]    ONE_N   = '1;
    localparam logic [AW:0]             DEPTH_N = (AW+1)'(DEPTH);
    localparam logic [EW-1:0]           EP_LAST = EW'(MAX_EPOCH - 1);
    localparam logic [IW-1:0]           I_LAST  = IW'(N_IN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_MAC,
        S_DECIDE,
        S_UPDATE,
        S_EPOCH_END
    } state_t;

    state_t                   state_q;
    state_t                   state_nxt;

    // Sample word: {x[N_IN-1], ..., x[0], t}
    logic [SW-1:0]            mem [DEPTH];
    logic [SW-1:0]            smp_q;
    logic [AW:0]              n_q;
    logic [AW-1:0]            k_q;
    logic [IW-1:0]            i_q;
    logic                     u_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [DW-1:0]     w_q [N_IN];
    logic signed [DW-1:0]     b_q;
    logic [EW-1:0]            ep_q;
    logic                     conv_q;
    logic                     ready_q;

    logic                     t_pos;
    logic                     last_smp;
    logic                     y_pos;
    logic                     y_neg;
    logic                     match;
    logic signed [DW-1:0]     x_mac;
    logic signed [DW-1:0]     w_mac;
    logic signed [2*DW-1:0]   prod;
    logic signed [DW+1:0]     x_ext;
    logic signed [DW-1:0]     w_upd [N_IN];
    logic signed [DW-1:0]     b_upd;

    function automatic logic signed [DW-1:0] sat(input logic signed [DW+1:0] v);
        if (v > SAT_HI) begin
            return SAT_HI[DW-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[DW-1:0];
        end
        return v[DW-1:0];
    endfunction

    assign t_pos    = smp_q[0];
    assign last_smp = ({1'b0, k_q} == (n_q - 1'b1));
    assign y_pos    = (acc_q > TH_POS);
    assign y_neg    = (acc_q < TH_NEG);
    // Output is 0 inside the dead band, which never matches a bipolar target.
    assign match    = t_pos ? y_pos : y_neg;

    // Select the current MAC lane and form its product.
    always_comb begin
        x_mac = smp_q[1 + int'(i_q) * DW +: DW];
        w_mac = w_q[i_q];
        prod  = w_mac * x_mac;
    end

    // Saturating update values for every lane and the bias.
    always_comb begin
        x_ext = '0;
        for (int i = 0; i < N_IN; i++) begin
            x_ext    = $signed({{2{smp_q[1 + i*DW + DW - 1]}}, smp_q[1 + i*DW +: DW]});
            w_upd[i] = sat($signed({{2{w_q[i][DW-1]}}, w_q[i]}) + (t_pos ? x_ext : -x_ext));
        end
        b_upd = sat($signed({{2{b_q[DW-1]}}, b_q}) + (t_pos ? ONE_P : ONE_N));
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:      if (start) state_nxt = S_CLEAR;
            S_CLEAR:     state_nxt = (n_q == '0) ? S_IDLE : S_FETCH;
            S_FETCH:     state_nxt = S_MAC;
            S_MAC:       if (i_q == I_LAST) state_nxt = S_DECIDE;
            S_DECIDE: begin
                if (!match)       state_nxt = S_UPDATE;
                else if (last_smp) state_nxt = S_EPOCH_END;
                else               state_nxt = S_FETCH;
            end
            S_UPDATE:    state_nxt = last_smp ? S_EPOCH_END : S_FETCH;
            S_EPOCH_END: state_nxt = (!u_q || ep_q == EP_LAST) ? S_IDLE : S_FETCH;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_nxt;
    end

    // Sample RAM write port; only open while idle, contents survive reset.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && wr_en) mem[wr_addr] <= {wr_x, wr_t};
    end

    // Training datapath and registered status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp_q   <= '0;
            n_q     <= '0;
            k_q     <= '0;
            i_q     <= '0;
            u_q     <= 1'b0;
            acc_q   <= '0;
            for (int i = 0; i < N_IN; i++) w_q[i] <= '0;
            b_q     <= '0;
            ep_q    <= '0;
            conv_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            ready_q <= (state_nxt == S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (start) n_q <= (n_samples > DEPTH_N) ? DEPTH_N : n_samples;
                end
                S_CLEAR: begin
                    for (int i = 0; i < N_IN; i++) w_q[i] <= '0;
                    b_q    <= '0;
                    ep_q   <= '0;
                    conv_q <= (n_q == '0);
                    k_q    <= '0;
                    u_q    <= 1'b0;
                end
                S_FETCH: begin
                    smp_q <= mem[k_q];
                    acc_q <= {{(ACC_W-DW){b_q[DW-1]}}, b_q};
                    i_q   <= '0;
                end
                S_MAC: begin
                    acc_q <= acc_q + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
                    i_q   <= i_q + 1'b1;
                end
                S_DECIDE: begin
                    if (match && !last_smp) k_q <= k_q + 1'b1;
                end
                S_UPDATE: begin
                    for (int i = 0; i < N_IN; i++) w_q[i] <= w_upd[i];
                    b_q <= b_upd;
                    u_q <= 1'b1;
                    if (!last_smp) k_q <= k_q + 1'b1;
                end
                S_EPOCH_END: begin
                    ep_q <= ep_q + 1'b1;
                    if (!u_q) begin
                        conv_q <= 1'b1;
                    end else begin
                        k_q <= '0;
                        u_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pack the weight vector onto the output bus.
    always_comb begin
        weights = '0;
        for (int i = 0; i < N_IN; i++) weights[i*DW +: DW] = w_q[i];
    end

    assign bias      = b_q;
    assign epochs    = ep_q;
    assign converged = conv_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_perceptron_trainer_n.sv
// Bench for perceptron_trainer_n: one instance at the default size and one
// narrow instance with a nonzero threshold where saturation is easy to reach.
// Results are compared against an arithmetic model of the training rule.
module tb_perceptron_trainer_n;

    localparam int DWA = 14, DPA = 16, MEA = 64, THA = 0;
    localparam int DWS = 4,  DPS = 4,  MES = 20, THS = 7;
    localparam int AWA = 4,  EWA = 7,  AWS = 2,  EWS = 5;
    localparam int LIMIT = 20000;

    logic clk = 1'b0;
    logic rst;

    logic               start_a, wr_en_a, wr_t_a, ready_a, conv_a;
    logic [AWA-1:0]     wr_addr_a;
    logic [2*DWA-1:0]   wr_x_a, w_a;
    logic [AWA:0]       n_a;
    logic [EWA-1:0]     ep_a;
    logic [DWA-1:0]     b_a;

    logic               start_s, wr_en_s, wr_t_s, ready_s, conv_s;
    logic [AWS-1:0]     wr_addr_s;
    logic [2*DWS-1:0]   wr_x_s, w_s;
    logic [AWS:0]       n_s;
    logic [EWS-1:0]     ep_s;
    logic [DWS-1:0]     b_s;

    int n_checks = 0;
    int n_fail   = 0;

    int mxa [DPA][2];
    int mta [DPA];
    int mxs [DPS][2];
    int mts [DPS];

    always #5 clk = ~clk;

    perceptron_trainer_n #(.N_IN(2), .DW(DWA), .DEPTH(DPA), .MAX_EPOCH(MEA), .THETA(THA)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_x(wr_x_a), .wr_t(wr_t_a), .n_samples(n_a), .ready(ready_a),
        .converged(conv_a), .epochs(ep_a), .weights(w_a), .bias(b_a)
    );

    perceptron_trainer_n #(.N_IN(2), .DW(DWS), .DEPTH(DPS), .MAX_EPOCH(MES), .THETA(THS)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .wr_en(wr_en_s), .wr_addr(wr_addr_s),
        .wr_x(wr_x_s), .wr_t(wr_t_s), .n_samples(n_s), .ready(ready_s),
        .converged(conv_s), .epochs(ep_s), .weights(w_s), .bias(b_s)
    );

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Training rule applied directly to the stored samples.
    task automatic model(input bit sel, input int nsamp, output int w0, output int w1,
                         output int b, output int ep, output int conv, output int cyc);
        int dw, th, me, dep, nn, lo, hi, acc, t, x0, x1, upd;
        dw  = sel ? DWS : DWA;
        th  = sel ? THS : THA;
        me  = sel ? MES : MEA;
        dep = sel ? DPS : DPA;
        nn  = (nsamp > dep) ? dep : nsamp;
        lo  = -(1 << (dw - 1));
        hi  = (1 << (dw - 1)) - 1;
        w0 = 0; w1 = 0; b = 0; ep = 0; conv = 0; cyc = 1;
        if (nn == 0) begin
            conv = 1;
            return;
        end
        do begin
            upd = 0;
            for (int k = 0; k < nn; k++) begin
                x0 = sel ? mxs[k][0] : mxa[k][0];
                x1 = sel ? mxs[k][1] : mxa[k][1];
                t  = sel ? mts[k] : mta[k];
                acc = b + w0 * x0 + w1 * x1;
                cyc += 4;
                if (!((t > 0 && acc > th) || (t < 0 && acc < -th))) begin
                    cyc++;
                    upd = 1;
                    w0 = clamp(w0 + t * x0, lo, hi);
                    w1 = clamp(w1 + t * x1, lo, hi);
                    b  = clamp(b + t, lo, hi);
                end
            end
            cyc++;
            ep++;
        end while (upd != 0 && ep < me);
        conv = (upd == 0) ? 1 : 0;
    endtask

    task automatic drive_wr(input bit sel, input int addr, input int x0, input int x1, input int t);
        logic [31:0] a0, a1, ad;
        a0 = x0; a1 = x1; ad = addr;
        if (!sel) begin
            wr_en_a = 1'b1; wr_addr_a = ad[AWA-1:0];
            wr_x_a = {a1[DWA-1:0], a0[DWA-1:0]}; wr_t_a = (t > 0);
            mxa[addr][0] = x0; mxa[addr][1] = x1; mta[addr] = t;
        end else begin
            wr_en_s = 1'b1; wr_addr_s = ad[AWS-1:0];
            wr_x_s = {a1[DWS-1:0], a0[DWS-1:0]}; wr_t_s = (t > 0);
            mxs[addr][0] = x0; mxs[addr][1] = x1; mts[addr] = t;
        end
    endtask

    task automatic wr(input bit sel, input int addr, input int x0, input int x1, input int t);
        @(negedge clk);
        drive_wr(sel, addr, x0, x1, t);
        @(negedge clk);
        wr_en_a = 1'b0;
        wr_en_s = 1'b0;
    endtask

    // Pulse start (optionally with a concurrent write), then count edges to ready.
    // inj_wr / inj_st inject a write and a start into instance A while busy.
    task automatic run(input bit sel, input int nsamp, input bit cw, input int cw_addr,
                       input int cw_x0, input int cw_x1, input int cw_t,
                       input int inj_wr, input int inj_st, output int cyc);
        logic [31:0] ns;
        ns = nsamp;
        @(negedge clk);
        if (cw) drive_wr(sel, cw_addr, cw_x0, cw_x1, cw_t);
        if (!sel) begin n_a = ns[AWA:0]; start_a = 1'b1; end
        else      begin n_s = ns[AWS:0]; start_s = 1'b1; end
        @(posedge clk);
        #1;
        start_a = 1'b0; start_s = 1'b0; wr_en_a = 1'b0; wr_en_s = 1'b0;
        chk("busy_after_start", sel ? ready_s : ready_a, 0);
        cyc = 0;
        while (1) begin
            @(posedge clk);
            #1;
            cyc++;
            start_a = 1'b0; start_s = 1'b0; wr_en_a = 1'b0; wr_en_s = 1'b0;
            if ((sel ? ready_s : ready_a) == 1'b1) break;
            if (cyc >= LIMIT) begin
                chk("run_timeout", 1, 0);
                break;
            end
            if (cyc == inj_wr) begin
                wr_en_a = 1'b1; wr_addr_a = 1;
                wr_x_a = {DWA'(-5), DWA'(5)}; wr_t_a = 1'b0;
            end
            if (cyc == inj_st) start_a = 1'b1;
        end
    endtask

    task automatic check_res(input bit sel, input string tag, input int w0, input int w1,
                             input int b, input int ep, input int conv);
        if (!sel) begin
            chk({tag, ".w0"},   $signed(w_a[DWA-1:0]), w0);
            chk({tag, ".w1"},   $signed(w_a[2*DWA-1:DWA]), w1);
            chk({tag, ".bias"}, $signed(b_a), b);
            chk({tag, ".epochs"}, ep_a, ep);
            chk({tag, ".conv"}, conv_a, conv);
        end else begin
            chk({tag, ".w0"},   $signed(w_s[DWS-1:0]), w0);
            chk({tag, ".w1"},   $signed(w_s[2*DWS-1:DWS]), w1);
            chk({tag, ".bias"}, $signed(b_s), b);
            chk({tag, ".epochs"}, ep_s, ep);
            chk({tag, ".conv"}, conv_s, conv);
        end
    endtask

    task automatic mrun(input bit sel, input string tag, input int nsamp, input int model_n);
        int w0, w1, b, ep, conv, mcyc, cyc;
        model(sel, model_n, w0, w1, b, ep, conv, mcyc);
        run(sel, nsamp, 1'b0, 0, 0, 0, 0, -1, -1, cyc);
        check_res(sel, tag, w0, w1, b, ep, conv);
        chk({tag, ".cycles"}, cyc, mcyc);
    endtask

    task automatic and_load();
        wr(0, 0,  1,  1,  1);
        wr(0, 1,  1, -1, -1);
        wr(0, 2, -1,  1, -1);
        wr(0, 3, -1, -1, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int cyc, n;
        rst = 1'b0;
        start_a = 0; wr_en_a = 0; wr_addr_a = '0; wr_x_a = '0; wr_t_a = 0; n_a = '0;
        start_s = 0; wr_en_s = 0; wr_addr_s = '0; wr_x_s = '0; wr_t_s = 0; n_s = '0;
        #12;
        check_res(0, "reset", 0, 0, 0, 0, 0);
        chk("reset.ready", ready_a, 1);
        chk("reset_s.ready", ready_s, 1);
        @(negedge clk);
        rst = 1'b1;

        // Bipolar AND; the last sample is written on the same edge as start.
        wr(0, 0,  1,  1,  1);
        wr(0, 1,  1, -1, -1);
        wr(0, 2, -1,  1, -1);
        run(0, 4, 1'b1, 3, -1, -1, -1, -1, -1, cyc);
        check_res(0, "and", 1, 1, -1, 2, 1);
        chk("and.cycles", cyc, 38);

        // Write and start while busy must be ignored.
        run(0, 4, 1'b0, 0, 0, 0, 0, 5, 30, cyc);
        check_res(0, "ignored", 1, 1, -1, 2, 1);
        chk("ignored.cycles", cyc, 38);

        // Reset in epoch 1 clears results asynchronously; RAM is kept.
        @(negedge clk);
        n_a = 4; start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("midrun.busy", ready_a, 0);
        rst = 1'b0;
        #1;
        chk("midrun_rst.ready", ready_a, 1);
        chk("midrun_rst.w", w_a, 0);
        chk("midrun_rst.bias", b_a, 0);
        chk("midrun_rst.epochs", ep_a, 0);
        @(negedge clk);
        rst = 1'b1;
        run(0, 4, 1'b0, 0, 0, 0, 0, -1, -1, cyc);
        check_res(0, "and_after_rst", 1, 1, -1, 2, 1);
        chk("and_after_rst.cycles", cyc, 38);

        // Bipolar XOR never converges.
        wr(0, 0,  1,  1, -1);
        wr(0, 1,  1, -1,  1);
        wr(0, 2, -1,  1,  1);
        wr(0, 3, -1, -1, -1);
        mrun(0, "xor", 4, 4);
        chk("xor.epochs_limit", ep_a, 64);
        chk("xor.not_conv", conv_a, 0);

        // Empty run: one CLEAR cycle, converged, everything zeroed.
        run(0, 0, 1'b0, 0, 0, 0, 0, -1, -1, cyc);
        check_res(0, "n0", 0, 0, 0, 0, 1);
        chk("n0.cycles", cyc, 1);

        // Full memory, then an over-range count that must clamp to DEPTH.
        for (int k = 0; k < DPA; k++)
            wr(0, k, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 6)) - 3,
               ($urandom_range(0, 1) != 0) ? 1 : -1);
        mrun(0, "n16", 16, 16);
        mrun(0, "n31", 31, 16);

        // Random runs on the wide instance.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 6; k++)
                wr(0, int'($urandom_range(0, DPA - 1)), int'($urandom_range(0, 8)) - 4,
                   int'($urandom_range(0, 8)) - 4, ($urandom_range(0, 1) != 0) ? 1 : -1);
            n = int'($urandom_range(1, 16));
            mrun(0, "rnd_a", n, n);
        end

        // Narrow instance: threshold 7 and 4-bit saturation.
        wr(1, 0, 7, 7, 1);
        mrun(1, "sat_single", 1, 1);
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < DPS; k++)
                wr(1, k, int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                   ($urandom_range(0, 1) != 0) ? 1 : -1);
            n = int'($urandom_range(0, 7));
            mrun(1, "rnd_s", n, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
